clk_switch_ctrl: RTL and testbench

//  Controller for the two-input glitch-free clock switch.
//  - Accepts source-change requests over a valid/ready handshake and checks that the target source is alive.
//  - Drives clk_select, then holds busy for a fixed settle window before committing the new selection.
//  - Optionally fails over automatically when the active source dies.
//  - Runs on an always-on control clock and sits between software/power-management logic and clk_switch.

---
 rtl/clk_switch_ctrl_pkg.sv | 12 +
 rtl/sync_2ff.sv | 27 ++
 rtl/clk_switch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_clk_switch_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_switch_ctrl_pkg.sv
// Shared definitions for the clock-switch controller: FSM encoding and the
// settle-window legality check used at elaboration.

`define CLK_SWITCH_CTRL_SETTLE_OK(cycles, cnt_w) (((cycles) >= 1) && ((cycles) <= ((1 << (cnt_w)) - 1)))

package clk_switch_ctrl_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_REVERT = 2'd2;

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchroniser for a level that is asynchronous to clk.
// Synchronous reset clears both stages.

module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic sync_r;

   // Two-stage capture of the asynchronous input
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/clk_switch_ctrl.sv
// Controller for the two-input glitch-free clock switch: request handshake,
// settle window before commit, abort/revert and optional automatic failover.

module clk_switch_ctrl
   import clk_switch_ctrl_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned CNT_W         = 8,
   parameter bit          RESET_SEL     = 1'b0,
   parameter bit          AUTO_FAILOVER = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic       req_sel,
   output logic       req_ready,
   input  logic [1:0] src_alive,
   output logic       clk_select,
   output logic       cur_sel,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       failover,
   output logic       no_clk
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   if (!`CLK_SWITCH_CTRL_SETTLE_OK(SETTLE_CYCLES, CNT_W)) begin : g_settle_illegal
      $error("clk_switch_ctrl: SETTLE_CYCLES out of range for CNT_W");
   end

   logic [1:0]       alive_s;
   logic             fo_cond_s;

   logic [1:0]       state_r,      state_next_s;
   logic [CNT_W-1:0] cnt_r,        cnt_next_s;
   logic             clk_select_r, clk_select_next_s;
   logic             cur_sel_r,    cur_sel_next_s;
   logic             busy_r,       busy_next_s;
   logic             fo_flag_r,    fo_flag_next_s;
   logic             done_r,       done_next_s;
   logic             err_r,        err_next_s;
   logic             failover_r,   failover_next_s;

   for (genvar i = 0; i < 2; i++) begin : g_sync
      sync_2ff u_sync (
         .clk (clk),
         .rst (rst),
         .d   (src_alive[i]),
         .q   (alive_s[i])
      );
   end

   // Failover takes the IDLE edge away from any pending request
   assign fo_cond_s = AUTO_FAILOVER & ~alive_s[cur_sel_r] & alive_s[~cur_sel_r];

   // Next-state, counter and pulse decode
   always_comb begin
      state_next_s      = state_r;
      cnt_next_s        = cnt_r;
      clk_select_next_s = clk_select_r;
      cur_sel_next_s    = cur_sel_r;
      busy_next_s       = busy_r;
      fo_flag_next_s    = fo_flag_r;
      done_next_s       = 1'b0;
      err_next_s        = 1'b0;
      failover_next_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (fo_cond_s) begin
               clk_select_next_s = ~cur_sel_r;
               cnt_next_s        = CNT_LOAD;
               fo_flag_next_s    = 1'b1;
               busy_next_s       = 1'b1;
               state_next_s      = ST_SETTLE;
            end else if (req_valid) begin
               if (req_sel == cur_sel_r) begin
                  done_next_s = 1'b1;
               end else if (!alive_s[req_sel]) begin
                  err_next_s = 1'b1;
               end else begin
                  clk_select_next_s = req_sel;
                  cnt_next_s        = CNT_LOAD;
                  busy_next_s       = 1'b1;
                  state_next_s      = ST_SETTLE;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (!alive_s[clk_select_r]) begin
               clk_select_next_s = cur_sel_r;
               cnt_next_s        = CNT_LOAD;
               state_next_s      = ST_REVERT;
            end else if (cnt_r == CNT_ZERO) begin
               cur_sel_next_s = clk_select_r;
               busy_next_s    = 1'b0;
               fo_flag_next_s = 1'b0;
               state_next_s   = ST_IDLE;
               if (fo_flag_r) begin
                  failover_next_s = 1'b1;
               end else begin
                  done_next_s = 1'b1;
               end
            end else begin
               cnt_next_s = cnt_r - CNT_ONE;
            end
         end
         ST_REVERT: begin
            if (cnt_r == CNT_ZERO) begin
               err_next_s     = 1'b1;
               busy_next_s    = 1'b0;
               fo_flag_next_s = 1'b0;
               state_next_s   = ST_IDLE;
            end else begin
               cnt_next_s = cnt_r - CNT_ONE;
            end
         end
         default: begin
            clk_select_next_s = cur_sel_r;
            cnt_next_s        = CNT_ZERO;
            busy_next_s       = 1'b0;
            fo_flag_next_s    = 1'b0;
            state_next_s      = ST_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         cnt_r        <= CNT_ZERO;
         clk_select_r <= RESET_SEL;
         cur_sel_r    <= RESET_SEL;
         busy_r       <= 1'b0;
         fo_flag_r    <= 1'b0;
         done_r       <= 1'b0;
         err_r        <= 1'b0;
         failover_r   <= 1'b0;
      end else begin
         state_r      <= state_next_s;
         cnt_r        <= cnt_next_s;
         clk_select_r <= clk_select_next_s;
         cur_sel_r    <= cur_sel_next_s;
         busy_r       <= busy_next_s;
         fo_flag_r    <= fo_flag_next_s;
         done_r       <= done_next_s;
         err_r        <= err_next_s;
         failover_r   <= failover_next_s;
      end
   end

   assign req_ready  = (state_r == ST_IDLE) & ~fo_cond_s;
   assign clk_select = clk_select_r;
   assign cur_sel    = cur_sel_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign err        = err_r;
   assign failover   = failover_r;
   assign no_clk     = ~alive_s[cur_sel_r];

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed bench for clk_switch_ctrl with default parameters. Status vector
// order: {clk_select, cur_sel, busy, done, err, failover, no_clk, req_ready}.

module tb_clk_switch_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_sel;
   logic       req_ready;
   logic [1:0] src_alive;
   logic       clk_select;
   logic       cur_sel;
   logic       busy;
   logic       done;
   logic       err;
   logic       failover;
   logic       no_clk;
   logic [7:0] st;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   clk_switch_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_sel    (req_sel),
      .req_ready  (req_ready),
      .src_alive  (src_alive),
      .clk_select (clk_select),
      .cur_sel    (cur_sel),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .failover   (failover),
      .no_clk     (no_clk)
   );

   assign st = {clk_select, cur_sel, busy, done, err, failover, no_clk, req_ready};

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Present a request for one edge; returns at the negedge after acceptance
   task automatic req(input logic s);
      req_valid = 1'b1;
      req_sel   = s;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; req_valid = 1'b0; req_sel = 1'b0; src_alive = 2'b11;
      cyc(2);
      tests_run++;
      if (st !== 8'b0000_0011) begin tests_failed++; $display("FAIL reset_state: got %b exp %b", st, 8'b0000_0011); end
      rst = 1'b0;
      cyc(1);
      tests_run++;
      if (st !== 8'b0000_0011) begin tests_failed++; $display("FAIL sync_latency: got %b exp %b", st, 8'b0000_0011); end
      cyc(1);
      tests_run++;
      if (st !== 8'b0000_0001) begin tests_failed++; $display("FAIL alive_synced: got %b exp %b", st, 8'b0000_0001); end
   endtask

   task automatic test_switch;
      req(1'b1);
      tests_run++;
      if (st !== 8'b1010_0000) begin tests_failed++; $display("FAIL switch_accept: got %b exp %b", st, 8'b1010_0000); end
      for (int k = 1; k <= 15; k++) begin
         cyc(1);
         tests_run++;
         if (st !== 8'b1010_0000) begin tests_failed++; $display("FAIL switch_settle[%0d]: got %b exp %b", k, st, 8'b1010_0000); end
      end
      cyc(1);
      tests_run++;
      if (st !== 8'b1101_0001) begin tests_failed++; $display("FAIL switch_done: got %b exp %b", st, 8'b1101_0001); end
      cyc(1);
      tests_run++;
      if (st !== 8'b1100_0001) begin tests_failed++; $display("FAIL switch_done_pulse: got %b exp %b", st, 8'b1100_0001); end
   endtask

   task automatic test_same_sel;
      req(1'b1);
      tests_run++;
      if (st !== 8'b1101_0001) begin tests_failed++; $display("FAIL same_sel_done: got %b exp %b", st, 8'b1101_0001); end
      cyc(1);
      tests_run++;
      if (st !== 8'b1100_0001) begin tests_failed++; $display("FAIL same_sel_after: got %b exp %b", st, 8'b1100_0001); end
   endtask

   task automatic test_dead_target;
      src_alive = 2'b10;
      cyc(3);
      tests_run++;
      if (st !== 8'b1100_0001) begin tests_failed++; $display("FAIL dead_target_idle: got %b exp %b", st, 8'b1100_0001); end
      req(1'b0);
      tests_run++;
      if (st !== 8'b1100_1001) begin tests_failed++; $display("FAIL dead_target_err: got %b exp %b", st, 8'b1100_1001); end
      cyc(1);
      tests_run++;
      if (st !== 8'b1100_0001) begin tests_failed++; $display("FAIL dead_target_after: got %b exp %b", st, 8'b1100_0001); end
   endtask

   task automatic test_abort;
      src_alive = 2'b11;
      cyc(3);
      req(1'b0);
      tests_run++;
      if (st !== 8'b0110_0000) begin tests_failed++; $display("FAIL abort_accept: got %b exp %b", st, 8'b0110_0000); end
      cyc(5);
      src_alive = 2'b10;
      for (int k = 6; k <= 7; k++) begin
         cyc(1);
         tests_run++;
         if (st !== 8'b0110_0000) begin tests_failed++; $display("FAIL abort_sync[%0d]: got %b exp %b", k, st, 8'b0110_0000); end
      end
      cyc(1);
      tests_run++;
      if (st !== 8'b1110_0000) begin tests_failed++; $display("FAIL abort_revert: got %b exp %b", st, 8'b1110_0000); end
      for (int k = 1; k <= 15; k++) begin
         cyc(1);
         tests_run++;
         if (st !== 8'b1110_0000) begin tests_failed++; $display("FAIL abort_window[%0d]: got %b exp %b", k, st, 8'b1110_0000); end
      end
      cyc(1);
      tests_run++;
      if (st !== 8'b1100_1001) begin tests_failed++; $display("FAIL abort_err: got %b exp %b", st, 8'b1100_1001); end
      cyc(1);
      tests_run++;
      if (st !== 8'b1100_0001) begin tests_failed++; $display("FAIL abort_after: got %b exp %b", st, 8'b1100_0001); end
   endtask

   task automatic test_failover;
      src_alive = 2'b01;
      cyc(1);
      tests_run++;
      if (st !== 8'b1100_0001) begin tests_failed++; $display("FAIL fo_presync: got %b exp %b", st, 8'b1100_0001); end
      cyc(1);
      tests_run++;
      if (st !== 8'b1100_0010) begin tests_failed++; $display("FAIL fo_ready_low: got %b exp %b", st, 8'b1100_0010); end
      cyc(1);
      tests_run++;
      if (st !== 8'b0110_0010) begin tests_failed++; $display("FAIL fo_start: got %b exp %b", st, 8'b0110_0010); end
      for (int k = 1; k <= 15; k++) begin
         cyc(1);
         tests_run++;
         if (st !== 8'b0110_0010) begin tests_failed++; $display("FAIL fo_settle[%0d]: got %b exp %b", k, st, 8'b0110_0010); end
      end
      cyc(1);
      tests_run++;
      if (st !== 8'b0000_0101) begin tests_failed++; $display("FAIL fo_pulse: got %b exp %b", st, 8'b0000_0101); end
      cyc(1);
      tests_run++;
      if (st !== 8'b0000_0001) begin tests_failed++; $display("FAIL fo_after: got %b exp %b", st, 8'b0000_0001); end
      src_alive = 2'b00;
      cyc(1);
      for (int k = 0; k < 5; k++) begin
         cyc(1);
         tests_run++;
         if (st !== 8'b0000_0011) begin tests_failed++; $display("FAIL both_dead[%0d]: got %b exp %b", k, st, 8'b0000_0011); end
      end
   endtask

   task automatic test_reset_mid_settle;
      src_alive = 2'b11;
      cyc(3);
      req(1'b1);
      tests_run++;
      if (st !== 8'b1010_0000) begin tests_failed++; $display("FAIL rst_mid_accept: got %b exp %b", st, 8'b1010_0000); end
      cyc(4);
      rst = 1'b1;
      cyc(1);
      tests_run++;
      if (st !== 8'b0000_0011) begin tests_failed++; $display("FAIL rst_mid_abort: got %b exp %b", st, 8'b0000_0011); end
      rst = 1'b0;
      cyc(1);
      tests_run++;
      if (st !== 8'b0000_0011) begin tests_failed++; $display("FAIL rst_mid_resync: got %b exp %b", st, 8'b0000_0011); end
      cyc(1);
      tests_run++;
      if (st !== 8'b0000_0001) begin tests_failed++; $display("FAIL rst_mid_idle: got %b exp %b", st, 8'b0000_0001); end
      req(1'b1);
      tests_run++;
      if (st !== 8'b1010_0000) begin tests_failed++; $display("FAIL rst_mid_reaccept: got %b exp %b", st, 8'b1010_0000); end
      cyc(16);
      tests_run++;
      if (st !== 8'b1101_0001) begin tests_failed++; $display("FAIL rst_mid_done: got %b exp %b", st, 8'b1101_0001); end
   endtask

   initial begin
      test_reset();
      test_switch();
      test_same_sel();
      test_dead_target();
      test_abort();
      test_failover();
      test_reset_mid_settle();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
